// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI register-frame master.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        HOLD  = 3'd4,
        GAP   = 3'd5
    } state_t;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    // Frame is R/W flag, then address, then data.
    function automatic int frame_len(input int a, input int d);
        return 1 + a + d;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period tick generator: tick is high on the last of every CLK_DIV cycles.
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign tick = !restart && (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master issuing one R/W register frame per accepted command.
// Handshake: a command transfers on a clk edge with cmd_valid && cmd_ready; cmd_ready is high only in IDLE.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int A       = 8,
    parameter int D       = 8,
    parameter int CLK_DIV = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_wr,
    input  logic [A-1:0] cmd_addr,
    input  logic [D-1:0] cmd_wdata,
    output logic         rsp_valid,
    output logic [D-1:0] rsp_rdata,
    output logic         busy,
    output logic         ss,
    output logic         sclk,
    output logic         mosi,
    input  logic         miso,
    output state_t       dbg_state
);

    localparam int N  = frame_len(A, D);
    localparam int BW = $clog2(N + 1);
    localparam logic [BW-1:0] FIRST_DATA = BW'(A + 1);
    localparam logic [BW-1:0] LAST_BIT   = BW'(N - 1);

    state_t         state_q, state_d;
    logic [BW-1:0]  bit_q, bit_d;
    logic [N-1:0]   sr_q, sr_d;
    logic           wr_q, wr_d;
    logic [D-1:0]   cap_q, cap_d;
    logic           ss_q, ss_d;
    logic           sclk_q, sclk_d;
    logic           mosi_q, mosi_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [D-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [D-1:0]   wdata_m;
    logic           tick;

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (state_q == IDLE),
        .tick    (tick)
    );

    assign wdata_m = (cmd_wr == RW_WRITE) ? cmd_wdata : '0;

    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        sr_d        = sr_q;
        wr_d        = wr_q;
        cap_d       = cap_q;
        ss_d        = ss_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = SETUP;
                    wr_d    = cmd_wr;
                    sr_d    = {wdata_m, cmd_addr, cmd_wr};
                    bit_d   = '0;
                    cap_d   = '0;
                    ss_d    = 1'b0;
                    sclk_d  = 1'b0;
                    mosi_d  = cmd_wr;
                end
            end
            SETUP, LOW: begin
                if (tick) begin
                    state_d = HIGH;
                    sclk_d  = 1'b1;
                end
            end
            HIGH: begin
                if (tick) begin
                    sclk_d = 1'b0;
                    // Data bits arrive LSB first, so shift in from the top.
                    if ((wr_q == RW_READ) && (bit_q >= FIRST_DATA)) begin
                        cap_d = {miso, cap_q[D-1:1]};
                    end
                    if (bit_q == LAST_BIT) begin
                        state_d = HOLD;
                    end else begin
                        state_d = LOW;
                        bit_d   = bit_q + 1'b1;
                        sr_d    = sr_q >> 1;
                        mosi_d  = sr_q[1];
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    state_d     = GAP;
                    ss_d        = 1'b1;
                    mosi_d      = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = cap_q;
                end
            end
            GAP: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                ss_d    = 1'b1;
                sclk_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_q       <= '0;
            sr_q        <= '0;
            wr_q        <= 1'b0;
            cap_q       <= '0;
            ss_q        <= 1'b1;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            bit_q       <= bit_d;
            sr_q        <= sr_d;
            wr_q        <= wr_d;
            cap_q       <= cap_d;
            ss_q        <= ss_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign ss        = ss_q;
    assign sclk      = sclk_q;
    assign mosi      = mosi_q;
    assign dbg_state = state_q;

endmodule
